competition_ctrl: RTL and testbench
===================================

COMPETITION_CTRL -- requirements
Module: competition_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per countdown tick (1 s at 100 MHz).
REQ-002 SHALL have parameter ANSWER_SEC, default 9, countdown load value (4-bit, 0..15).
REQ-003 SHALL have parameter BUZZ_CYC, default 10000000, buzzer pulse length in clk cycles.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  host start pulse, one cycle, already debounced.
REQ-007 host_ok  input  1  host "correct" pulse, one cycle.
REQ-008 host_ng  input  1  host "wrong" pulse, one cycle.
REQ-009 key  input  8  player buttons, debounced, active-high levels.
REQ-010 view  output  3  display page: 0 idle, 1 armed, 2 answer, 3 result.
REQ-011 play_count  output  4  rounds started, modulo 16.
REQ-012 winner  output  3  index of buzzed-in player.
REQ-013 countdown  output  4  remaining answer seconds.
REQ-014 result  output  1  1 = last round judged correct.
REQ-015 led  output  8  one-hot winner indicator.
REQ-016 buzzer  output  1  audible pulse, active-high.

Function
REQ-017 FSM states SHALL be IDLE, ARMED, ANSWER, RESULT; view SHALL equal the state code 0/1/2/3, registered.
REQ-018 IDLE or RESULT + start SHALL go to ARMED next edge and increment play_count on that edge (15 wraps to 0).
REQ-019 start in ARMED or ANSWER SHALL be ignored.
REQ-020 key SHALL be registered each cycle; rise[i] = key[i] & ~key_q[i]; only rises count, so keys held before ARMED never buzz in.
REQ-021 ARMED + any rise SHALL, on that edge, latch winner = lowest set rise index, enter ANSWER, load countdown = ANSWER_SEC, clear tick divider.
REQ-022 Simultaneous rises SHALL resolve to the lowest index; rises outside ARMED SHALL be ignored.
REQ-023 Tick SHALL be a one-cycle strobe every TICK_DIV cycles, free-running except cleared on ANSWER entry.
REQ-024 In ANSWER, tick with countdown>0 SHALL decrement; tick with countdown==0 SHALL time out: RESULT, result=0.
REQ-025 In ANSWER, host_ng SHALL go to RESULT with result=0; host_ok alone to RESULT with result=1; both together means ng wins; either beats a same-cycle tick.
REQ-026 host_ok/host_ng outside ANSWER SHALL be ignored.
REQ-027 buzzer SHALL go high the cycle after ANSWER entry or timeout, for exactly BUZZ_CYC cycles; a new trigger SHALL restart the full length.
REQ-028 led SHALL be one-hot of winner in ANSWER and RESULT, 0 otherwise.
REQ-029 winner, result, countdown SHALL hold their values until next overwritten.

Reset
REQ-030 rst low SHALL immediately force IDLE, view=0, play_count=0, winner=0, countdown=0, result=0, led=0, buzzer=0, key_q=0, tick divider and buzzer counter = 0.
REQ-031 Reset mid-round SHALL abort it with no buzzer and no count change after release.
REQ-032 First edge after rst release SHALL behave as IDLE; a key high at release SHALL count as a rise that cycle but IDLE ignores it.

Structure
REQ-033 State codes, view codes and player count (8) SHALL live in shared package competition_pkg.
REQ-034 Tick divider SHALL be sub-module tick_gen (ports clk, rst, clr, tick; parameter TICK_DIV).
REQ-035 FSM, arbiter, countdown and buzzer timer SHALL remain in competition_ctrl.

Verification (TICK_DIV=4, ANSWER_SEC=3, BUZZ_CYC=2)
REQ-036 Reset, then start -> view=1, play_count=1 next edge; 16 further rounds -> play_count=1 (wrap).
REQ-037 ARMED, key=8'b0010_0100 same cycle -> winner=2, led=8'b0000_0100, view=2, countdown=3, buzzer high 2 cycles.
REQ-038 key[5] held from IDLE through start -> no buzz-in; release then press -> winner=5.
REQ-039 ANSWER, no host input -> countdown 3,2,1,0 at 4-cycle ticks, next tick -> view=3, result=0, buzzer 2 cycles.
REQ-040 ANSWER, host_ok+host_ng same cycle -> result=0; host_ok alone -> result=1; start then ignored in ANSWER.
REQ-041 rst low during ANSWER with buzzer high -> all outputs 0 at once, view=0 after release.

Source files
------------

// File: rtl/competition_pkg.sv
// Shared definitions for the quiz competition controller: FSM state codes,
// display page codes, player count and the buzz-in priority helper.
package competition_pkg;

    localparam int NUM_PLAYERS = 8;
    localparam int PLAYER_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ANSWER = 3'd2,
        ST_RESULT = 3'd3
    } state_t;

    localparam logic [2:0] VIEW_IDLE   = 3'd0;
    localparam logic [2:0] VIEW_ARMED  = 3'd1;
    localparam logic [2:0] VIEW_ANSWER = 3'd2;
    localparam logic [2:0] VIEW_RESULT = 3'd3;

    // Display page shown for a given controller state.
    function automatic logic [2:0] view_code(input state_t st);
        logic [2:0] v;
        v = VIEW_IDLE;
        case (st)
            ST_IDLE:   v = VIEW_IDLE;
            ST_ARMED:  v = VIEW_ARMED;
            ST_ANSWER: v = VIEW_ANSWER;
            ST_RESULT: v = VIEW_RESULT;
            default:   v = VIEW_IDLE;
        endcase
        return v;
    endfunction

    // Lowest set bit index; simultaneous presses go to the lowest player.
    function automatic logic [PLAYER_W-1:0] lowest_index(input logic [NUM_PLAYERS-1:0] v);
        logic [PLAYER_W-1:0] idx;
        idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (v[i]) idx = PLAYER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/competition_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// clr restarts the period so the first tick after a restart is a full
// period away.
module tick_gen #(
    parameter int TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    // Period counter: wraps at LAST, restarted by clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/competition_ctrl.sv
// Quiz competition controller: arms a round on start, awards the first
// rising player key, runs the answer countdown, takes the host verdict and
// pulses the buzzer on buzz-in and on timeout.
module competition_ctrl
    import competition_pkg::*;
#(
    parameter int TICK_DIV   = 100000000,
    parameter int ANSWER_SEC = 9,
    parameter int BUZZ_CYC   = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       host_ok,
    input  logic       host_ng,
    input  logic [7:0] key,
    output logic [2:0] view,
    output logic [3:0] play_count,
    output logic [2:0] winner,
    output logic [3:0] countdown,
    output logic       result,
    output logic [7:0] led,
    output logic       buzzer
);

    localparam int            BW        = (BUZZ_CYC > 1) ? $clog2(BUZZ_CYC) : 1;
    localparam logic [BW-1:0] BUZZ_LOAD = BW'(BUZZ_CYC - 1);
    localparam logic [3:0]    CD_LOAD   = 4'(ANSWER_SEC);

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_PLAYERS-1:0] key_q;
    logic [NUM_PLAYERS-1:0] rise;
    logic                   tick;
    logic                   round_start;
    logic                   buzz_in;
    logic                   cd_dec;
    logic                   judge;
    logic                   judge_val;
    logic                   buzz_trig;
    logic [BW-1:0]          buzz_cnt;

    // Only fresh presses count, so a key held before arming never wins.
    assign rise = key & ~key_q;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (buzz_in),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; host verdict outranks a same-cycle tick.
    always_comb begin
        state_nxt   = state;
        round_start = 1'b0;
        buzz_in     = 1'b0;
        cd_dec      = 1'b0;
        judge       = 1'b0;
        judge_val   = 1'b0;
        buzz_trig   = 1'b0;
        case (state)
            ST_IDLE, ST_RESULT: begin
                if (start) begin
                    state_nxt   = ST_ARMED;
                    round_start = 1'b1;
                end
            end
            ST_ARMED: begin
                if (|rise) begin
                    state_nxt = ST_ANSWER;
                    buzz_in   = 1'b1;
                    buzz_trig = 1'b1;
                end
            end
            ST_ANSWER: begin
                if (host_ng) begin
                    state_nxt = ST_RESULT;
                    judge     = 1'b1;
                    judge_val = 1'b0;
                end else if (host_ok) begin
                    state_nxt = ST_RESULT;
                    judge     = 1'b1;
                    judge_val = 1'b1;
                end else if (tick) begin
                    if (countdown != 4'd0) begin
                        cd_dec = 1'b1;
                    end else begin
                        state_nxt = ST_RESULT;
                        judge     = 1'b1;
                        judge_val = 1'b0;
                        buzz_trig = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Display page follows the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            view <= VIEW_IDLE;
        end else begin
            view <= view_code(state_nxt);
        end
    end

    // Key history for rise detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q <= '0;
        end else begin
            key_q <= key;
        end
    end

    // Rounds started, wrapping modulo 16.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            play_count <= 4'd0;
        end else if (round_start) begin
            play_count <= play_count + 4'd1;
        end
    end

    // Winner latched at buzz-in and held until the next buzz-in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            winner <= '0;
        end else if (buzz_in) begin
            winner <= lowest_index(rise);
        end
    end

    // Answer countdown: loaded at buzz-in, decremented on each tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            countdown <= 4'd0;
        end else if (buzz_in) begin
            countdown <= CD_LOAD;
        end else if (cd_dec) begin
            countdown <= countdown - 4'd1;
        end
    end

    // Verdict of the last judged round.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= 1'b0;
        end else if (judge) begin
            result <= judge_val;
        end
    end

    // Buzzer pulse timer; a new trigger restarts the full length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buzzer   <= 1'b0;
            buzz_cnt <= '0;
        end else if (buzz_trig) begin
            buzzer   <= 1'b1;
            buzz_cnt <= BUZZ_LOAD;
        end else if (buzzer) begin
            if (buzz_cnt == '0) begin
                buzzer <= 1'b0;
            end else begin
                buzz_cnt <= buzz_cnt - BW'(1);
            end
        end
    end

    assign led = ((state == ST_ANSWER) || (state == ST_RESULT))
                 ? (NUM_PLAYERS'(1) << winner) : '0;

endmodule

// File: tb/tb_competition_ctrl.sv
// Directed bench for competition_ctrl with short tick/buzzer periods.
module tb_competition_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       host_ok;
    logic       host_ng;
    logic [7:0] key;
    logic [2:0] view;
    logic [3:0] play_count;
    logic [2:0] winner;
    logic [3:0] countdown;
    logic       result;
    logic [7:0] led;
    logic       buzzer;

    int n_checks = 0;
    int n_fail   = 0;

    competition_ctrl #(
        .TICK_DIV   (4),
        .ANSWER_SEC (3),
        .BUZZ_CYC   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .host_ok    (host_ok),
        .host_ng    (host_ng),
        .key        (key),
        .view       (view),
        .play_count (play_count),
        .winner     (winner),
        .countdown  (countdown),
        .result     (result),
        .led        (led),
        .buzzer     (buzzer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_view"},   view,       0);
        chk({tag, "_count"},  play_count, 0);
        chk({tag, "_winner"}, winner,     0);
        chk({tag, "_cd"},     countdown,  0);
        chk({tag, "_result"}, result,     0);
        chk({tag, "_led"},    led,        0);
        chk({tag, "_buzzer"}, buzzer,     0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; host_ok = 1'b0; host_ng = 1'b0; key = 8'h00;
        step(3);
        chk_all_zero("reset");

        rst = 1'b1;
        step(1);
        chk("idle_after_rst", view, 0);

        // first round: arm, simultaneous presses on players 2 and 5
        start = 1'b1; step(1); start = 1'b0;
        chk("arm_view",  view,       1);
        chk("arm_count", play_count, 1);

        key = 8'b0010_0100; step(1);
        chk("bi_view",   view,      2);
        chk("bi_winner", winner,    2);
        chk("bi_led",    led,       8'b0000_0100);
        chk("bi_cd",     countdown, 3);
        chk("bi_buzz1",  buzzer,    1);
        key = 8'h00; step(1);
        chk("bi_buzz2",  buzzer,    1);
        step(1);
        chk("bi_buzz_off", buzzer,  0);

        // countdown with no host input
        step(1);
        chk("cd_hold3", countdown, 3);
        step(1);
        chk("cd_2", countdown, 2);
        step(4);
        chk("cd_1", countdown, 1);
        step(4);
        chk("cd_0", countdown, 0);
        step(3);
        chk("cd_0_still_answer", view, 2);
        step(1);
        chk("to_view",   view,      3);
        chk("to_result", result,    0);
        chk("to_buzz1",  buzzer,    1);
        chk("to_led",    led,       8'b0000_0100);
        chk("to_cd",     countdown, 0);
        step(1);
        chk("to_buzz2",  buzzer,    1);
        step(1);
        chk("to_buzz_off", buzzer,  0);

        // key held from before arming must not buzz in
        key = 8'b0010_0000; step(2);
        chk("rise_in_result_view",   view,   3);
        chk("rise_in_result_winner", winner, 2);
        start = 1'b1; step(1); start = 1'b0;
        chk("arm2_view",  view,       1);
        chk("arm2_count", play_count, 2);
        step(3);
        chk("held_key_no_buzz", view, 1);
        key = 8'h00; step(1);
        chk("release_view", view, 1);
        key = 8'b0010_0000; step(1); key = 8'h00;
        chk("p5_view",   view,   2);
        chk("p5_winner", winner, 5);
        chk("p5_led",    led,    8'b0010_0000);

        // start ignored in ANSWER; ok+ng together is wrong
        start = 1'b1; step(1); start = 1'b0;
        chk("start_ign_view",  view,       2);
        chk("start_ign_count", play_count, 2);
        host_ok = 1'b1; host_ng = 1'b1; step(1); host_ok = 1'b0; host_ng = 1'b0;
        chk("okng_view",   view,   3);
        chk("okng_result", result, 0);

        // host_ok alone is correct
        start = 1'b1; step(1); start = 1'b0;
        chk("arm3_count", play_count, 3);
        key = 8'h81; step(1); key = 8'h00;
        chk("p0_winner", winner, 0);
        chk("p0_led",    led,    8'h01);
        host_ok = 1'b1; step(1); host_ok = 1'b0;
        chk("ok_view",   view,   3);
        chk("ok_result", result, 1);
        host_ng = 1'b1; step(1); host_ng = 1'b0;
        chk("ng_ign_result", result, 1);
        chk("ng_ign_view",   view,   3);
        key = 8'h80; step(1); key = 8'h00;
        chk("key_ign_winner", winner, 0);
        host_ok = 1'b1; step(1); host_ok = 1'b0;
        chk("ok_ign_armed_free_view", view, 3);

        // sixteen more rounds wrap the counter back to 3
        for (int i = 0; i < 16; i++) begin
            start = 1'b1; step(1); start = 1'b0;
            chk("wrap_count", play_count, (4 + i) % 16);
            key = 8'h10; step(1); key = 8'h00;
            host_ng = 1'b1; step(1); host_ng = 1'b0;
        end
        chk("wrap_final_count",  play_count, 3);
        chk("wrap_final_view",   view,       3);
        chk("wrap_final_winner", winner,     4);

        // reset during ANSWER with the buzzer sounding
        start = 1'b1; step(1); start = 1'b0;
        key = 8'h02; step(1);
        chk("pre_rst_view",   view,   2);
        chk("pre_rst_buzzer", buzzer, 1);
        #1 rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step(1);
        rst = 1'b1;
        step(1);
        chk("post_rst_view",   view,       0);
        chk("post_rst_buzzer", buzzer,     0);
        chk("post_rst_count",  play_count, 0);
        start = 1'b1; step(1); start = 1'b0;
        chk("post_rst_arm_view",  view,       1);
        chk("post_rst_arm_count", play_count, 1);
        step(2);
        chk("post_rst_held_no_buzz", view, 1);
        key = 8'h00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
